// File: rtl/branch_outcome_scoreboard.sv
// In-order scoreboard pairing issued branch predictions with resolved outcomes.
// Produces registered hit/mispredict pulses, occupancy status and saturating accuracy counters.
module branch_outcome_scoreboard #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pred_valid,
   input  logic                         pred_bit,
   input  logic                         resolve_valid,
   input  logic                         resolve_taken,
   input  logic                         flush,
   output logic                         hit,
   output logic                         mispredict,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         full,
   output logic                         empty,
   output logic [CNT_W-1:0]             total_count,
   output logic [CNT_W-1:0]             miss_count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [DEPTH-1:0] pred_mem_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic             push_s;
   logic             pop_s;
   logic             miss_s;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic [OCC_W-1:0] occ_next_s;

   // Accept/score decisions from start-of-cycle state; a full queue still takes a push when popping.
   always_comb begin
      push_s     = 1'b0;
      pop_s      = 1'b0;
      miss_s     = 1'b0;
      ovf_set_s  = 1'b0;
      unf_set_s  = 1'b0;
      occ_next_s = outstanding;
      if (flush) begin
         occ_next_s = '0;
      end else begin
         pop_s     = resolve_valid & ~empty;
         push_s    = pred_valid & (~full | pop_s);
         miss_s    = pop_s & (pred_mem_r[rd_ptr_r] != resolve_taken);
         ovf_set_s = pred_valid & full & ~pop_s;
         unf_set_s = resolve_valid & empty;
         case ({push_s, pop_s})
            2'b10:   occ_next_s = outstanding + OCC_W'(1);
            2'b01:   occ_next_s = outstanding - OCC_W'(1);
            default: occ_next_s = outstanding;
         endcase
      end
   end

   // Prediction storage and circular pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_mem_r <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
      end else if (flush) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
      end else begin
         if (push_s) begin
            pred_mem_r[wr_ptr_r] <= pred_bit;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy status and score pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         hit         <= 1'b0;
         mispredict  <= 1'b0;
      end else begin
         outstanding <= occ_next_s;
         full        <= (occ_next_s == OCC_FULL);
         empty       <= (occ_next_s == '0);
         hit         <= pop_s & ~miss_s;
         mispredict  <= miss_s;
      end
   end

   // Saturating counters and sticky error flags survive flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         total_count <= '0;
         miss_count  <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (pop_s && (total_count != CNT_MAX)) begin
            total_count <= total_count + CNT_W'(1);
         end
         if (miss_s && (miss_count != CNT_MAX)) begin
            miss_count <= miss_count + CNT_W'(1);
         end
         if (ovf_set_s) begin
            overflow <= 1'b1;
         end
         if (unf_set_s) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_outcome_scoreboard.sv
// Bench for branch_outcome_scoreboard: hand-derived vector table plus a behavioural
// queue model whose expected pulses are pushed at drive time and popped after the edge.
module tb_branch_outcome_scoreboard;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic             clk;
   logic             rst;
   logic             pred_valid;
   logic             pred_bit;
   logic             resolve_valid;
   logic             resolve_taken;
   logic             flush;
   logic             hit;
   logic             mispredict;
   logic [2:0]       outstanding;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] total_count;
   logic [CNT_W-1:0] miss_count;
   logic             overflow;
   logic             underflow;

   branch_outcome_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pred_valid    (pred_valid),
      .pred_bit      (pred_bit),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .flush         (flush),
      .hit           (hit),
      .mispredict    (mispredict),
      .outstanding   (outstanding),
      .full          (full),
      .empty         (empty),
      .total_count   (total_count),
      .miss_count    (miss_count),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit rs, pv, pb, rv, rt, fl;
      bit eh, em;
      int eocc, etot;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   bit       pred_q[$];
   bit [1:0] exp_q[$];
   int       m_total, m_miss;
   bit       m_ovf, m_unf;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference behaviour evaluated on the state before the edge.
   task automatic model_update(input bit rs, pv, pb, rv, rt, fl);
      bit [1:0] pulse;
      bit       pop, push, p, m;
      pulse = 2'b00;
      if (rs) begin
         pred_q.delete();
         m_total = 0; m_miss = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (fl) begin
         pred_q.delete();
      end else begin
         pop  = rv && (pred_q.size() != 0);
         push = pv && ((pred_q.size() < DEPTH) || pop);
         if (rv && pred_q.size() == 0) m_unf = 1'b1;
         if (pv && pred_q.size() == DEPTH && !pop) m_ovf = 1'b1;
         if (pop) begin
            p = pred_q.pop_front();
            m = (p != rt);
            if (m_total < CNT_MAX) m_total++;
            if (m && m_miss < CNT_MAX) m_miss++;
            pulse = m ? 2'b01 : 2'b10;
         end
         if (push) pred_q.push_back(pb);
      end
      exp_q.push_back(pulse);
   endtask

   task automatic compare_all();
      bit [1:0] pulse;
      pulse = 2'b00;
      if (exp_q.size() != 0) pulse = exp_q.pop_front();
      chk("hit", int'(hit), int'(pulse[1]));
      chk("mispredict", int'(mispredict), int'(pulse[0]));
      chk("outstanding", int'(outstanding), pred_q.size());
      chk("full", int'(full), int'(pred_q.size() == DEPTH));
      chk("empty", int'(empty), int'(pred_q.size() == 0));
      chk("total_count", int'(total_count), m_total);
      chk("miss_count", int'(miss_count), m_miss);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
   endtask

   task automatic step(input bit rs, pv, pb, rv, rt, fl);
      rst = rs; pred_valid = pv; pred_bit = pb;
      resolve_valid = rv; resolve_taken = rt; flush = fl;
      model_update(rs, pv, pb, rv, rt, fl);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   function automatic vec_t v(input bit rs, pv, pb, rv, rt, fl, eh, em, input int eocc, etot);
      vec_t r;
      r.rs = rs; r.pv = pv; r.pb = pb; r.rv = rv; r.rt = rt; r.fl = fl;
      r.eh = eh; r.em = em; r.eocc = eocc; r.etot = etot;
      return r;
   endfunction

   vec_t tbl[33];

   initial begin
      rst = 1'b0; pred_valid = 1'b0; pred_bit = 1'b0;
      resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;

      //            rs pv pb rv rt fl  eh em occ tot
      tbl[0]  = v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      tbl[1]  = v(0, 1, 1, 0, 0, 0,  0, 0, 1, 0);
      tbl[2]  = v(0, 1, 0, 0, 0, 0,  0, 0, 2, 0);
      tbl[3]  = v(0, 1, 1, 0, 0, 0,  0, 0, 3, 0);
      tbl[4]  = v(0, 0, 0, 1, 1, 0,  1, 0, 2, 1);
      tbl[5]  = v(0, 0, 0, 1, 1, 0,  0, 1, 1, 2);
      tbl[6]  = v(0, 0, 0, 1, 1, 0,  1, 0, 0, 3);
      tbl[7]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
      tbl[8]  = v(0, 1, 1, 0, 0, 0,  0, 0, 1, 3);
      tbl[9]  = v(0, 1, 1, 0, 0, 0,  0, 0, 2, 3);
      tbl[10] = v(0, 1, 0, 0, 0, 0,  0, 0, 3, 3);
      tbl[11] = v(0, 1, 0, 0, 0, 0,  0, 0, 4, 3);
      tbl[12] = v(0, 1, 1, 0, 0, 0,  0, 0, 4, 3);
      tbl[13] = v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      tbl[14] = v(0, 1, 1, 0, 0, 0,  0, 0, 1, 0);
      tbl[15] = v(0, 1, 0, 0, 0, 0,  0, 0, 2, 0);
      tbl[16] = v(0, 1, 1, 0, 0, 0,  0, 0, 3, 0);
      tbl[17] = v(0, 1, 1, 0, 0, 0,  0, 0, 4, 0);
      tbl[18] = v(0, 1, 0, 1, 1, 0,  1, 0, 4, 1);
      tbl[19] = v(0, 0, 0, 1, 1, 0,  0, 1, 3, 2);
      tbl[20] = v(0, 0, 0, 1, 1, 0,  1, 0, 2, 3);
      tbl[21] = v(0, 0, 0, 1, 1, 0,  1, 0, 1, 4);
      tbl[22] = v(0, 0, 0, 1, 1, 0,  0, 1, 0, 5);
      tbl[23] = v(0, 1, 1, 1, 1, 0,  0, 0, 1, 5);
      tbl[24] = v(0, 0, 0, 1, 1, 0,  1, 0, 0, 6);
      tbl[25] = v(0, 1, 0, 0, 0, 0,  0, 0, 1, 6);
      tbl[26] = v(0, 1, 1, 0, 0, 0,  0, 0, 2, 6);
      tbl[27] = v(0, 1, 1, 0, 0, 0,  0, 0, 3, 6);
      tbl[28] = v(0, 1, 1, 1, 1, 1,  0, 0, 0, 6);
      tbl[29] = v(0, 1, 1, 0, 0, 0,  0, 0, 1, 6);
      tbl[30] = v(0, 1, 0, 1, 0, 0,  0, 1, 1, 7);
      tbl[31] = v(0, 0, 0, 1, 0, 0,  1, 0, 0, 8);
      tbl[32] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 8);

      for (int i = 0; i < 33; i++) begin
         step(tbl[i].rs, tbl[i].pv, tbl[i].pb, tbl[i].rv, tbl[i].rt, tbl[i].fl);
         chk($sformatf("tbl_hit[%0d]", i), int'(hit), int'(tbl[i].eh));
         chk($sformatf("tbl_mispredict[%0d]", i), int'(mispredict), int'(tbl[i].em));
         chk($sformatf("tbl_outstanding[%0d]", i), int'(outstanding), tbl[i].eocc);
         chk($sformatf("tbl_total[%0d]", i), int'(total_count), tbl[i].etot);
         if (i == 12) chk("tbl_overflow_after_drop", int'(overflow), 1);
         if (i == 18) chk("tbl_no_overflow_full_pushpop", int'(overflow), 0);
         if (i == 23) chk("tbl_underflow_empty_resolve", int'(underflow), 1);
      end

      // Saturation: 20 mispredicting resolves, pointers wrapping repeatedly.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      chk("sat_total", int'(total_count), 15);
      chk("sat_miss", int'(miss_count), 15);
      chk("sat_mispredict_pulse", int'(mispredict), 1);

      // Reset mid-stream overrides simultaneous push and resolve.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_total", int'(total_count), 0);
      chk("rst_miss", int'(miss_count), 0);
      chk("rst_outstanding", int'(outstanding), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_pulse", int'(hit | mispredict), 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_outcome_scoreboard.md
Name: branch_outcome_scoreboard

Overview:
- Downstream consumer of the 2-bit branch predictor.
- Queues each issued prediction bit in order, then pairs it with the actual branch outcome when that outcome resolves.
- Produces per-branch hit/mispredict pulses and saturating accuracy counters for the core's flush logic and for performance monitoring.
- In-order resolution only; one prediction and one resolution per cycle maximum.

Parameters:
- DEPTH, 4, number of outstanding (issued, unresolved) predictions held; power of 2, minimum 2.
- CNT_W, 16, width of the total and miss counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- pred_valid  input  1  predictor has issued a prediction this cycle.
- pred_bit  input  1  issued prediction (1 = taken).
- resolve_valid  input  1  oldest outstanding branch has resolved this cycle.
- resolve_taken  input  1  actual outcome of the resolving branch (1 = taken).
- flush  input  1  discard all outstanding predictions; counters are kept.
- hit  output  1  one-cycle pulse: the last resolve matched its prediction.
- mispredict  output  1  one-cycle pulse: the last resolve did not match its prediction.
- outstanding  output  $clog2(DEPTH+1)  current queue occupancy.
- full  output  1  outstanding == DEPTH.
- empty  output  1  outstanding == 0.
- total_count  output  CNT_W  resolves scored since reset (saturating).
- miss_count  output  CNT_W  mispredicts since reset (saturating).
- overflow  output  1  sticky: a push was dropped because the queue was full.
- underflow  output  1  sticky: a resolve arrived while the queue was empty.

Behaviour:
- Reset (rst=1 at edge):
  - Queue emptied; read and write pointers = 0.
  - outstanding=0, empty=1, full=0.
  - hit=0, mispredict=0, total_count=0, miss_count=0, overflow=0, underflow=0.
  - rst overrides all other inputs in that cycle.
- Push: pred_valid=1 and not full → pred_bit written at the write pointer; pointer increments modulo DEPTH.
- Pop/score: resolve_valid=1 and not empty → head entry compared with resolve_taken.
  - Next cycle: exactly one of hit/mispredict is 1. Latency is 1 cycle, registered.
  - total_count increments. miss_count increments on mismatch.
  - Read pointer increments modulo DEPTH.
- hit and mispredict are 0 in every cycle that does not follow a successful score.
- Full/empty and underflow conditions are evaluated on the state at the start of the cycle.
- Simultaneous push and pop while full: both accepted, occupancy unchanged, no overflow.
- Push while full without a pop: entry dropped, overflow set to 1 and held until rst.
- Resolve while empty: nothing scored, no pulse, underflow set to 1 and held until rst.
  - A push in the same cycle is still accepted.
  - No bypass: a prediction is never scored in the same cycle it is pushed.
- flush=1:
  - Pointers reset to 0 and occupancy becomes 0.
  - Any push or resolve in the same cycle is ignored: no counting, no pulses, no flag updates.
  - Counters and sticky flags are retained.
- Counter saturation: total_count and miss_count stop at all-ones and never wrap. miss_count ≤ total_count always.
- Pointer wrap-around is transparent; ordering is strictly FIFO across the wrap.
- outstanding, full and empty are registered and reflect state after the edge.

Test Plan:
- Reset, then push 1,0,1 on consecutive cycles, then resolve with taken 1,1,1 → pulses hit, mispredict, hit (each 1 cycle after its resolve); total_count=3, miss_count=1, empty=1.
- DEPTH=4: push 5 predictions with no resolves → full=1 after the 4th push; 5th push dropped; overflow=1; outstanding=4.
- While full (outstanding=4), push and resolve in the same cycle → outstanding stays 4, overflow stays 0, one pulse generated; entry order preserved.
- Resolve on an empty queue together with a push of 1 → underflow=1, no pulse, outstanding=1, total_count unchanged; resolve_taken=1 next cycle → hit.
- Push 3 entries, then assert flush together with a resolve → outstanding=0, no pulse, total_count unchanged; subsequent pushes/resolves pair correctly from pointer 0.
- CNT_W=4: perform 20 mispredicting resolves (wrapping the queue several times) → total_count=15, miss_count=15 (saturated); rst mid-stream clears all outputs next cycle.
